// File: rtl/control_sequencer.sv
// control_sequencer
//
// Hardwired multi-cycle control unit for the bus-based datapath. It fetches
// an instruction (T0..T2, with a wait state in T1 until memory is ready),
// then decodes the latched IR and steps through the execute phase for
// register ALU, unary, multiply/divide, nop and halt instructions.
//
// Ports:
//   clk          rising-edge clock shared with the datapath
//   clr          asynchronous active-high reset
//   ir           IR contents: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
//   mem_ready    memory data valid, only looked at in T1
//   PCout, ZLowout, ZHighout, MDRout       bus source selects
//   MARin, PCin, MDRin, IRin, Yin, ZLowIn,
//   ZHighIn, HIin, LOin                    register load enables
//   IncPC, Read                            PC increment / MDR takes MDatain
//   Rout         one-hot general-register bus source
//   Rin          one-hot general-register load (R0 never written)
//   operation    ALU opcode, driven only in T3/T4
//   run          high unless halted
//   instr_count  retired instruction counter (wraps)

module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [4:0]  operation,
    output logic        run,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t state, next_state;
    logic   retire;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_halt, is_exec, is_binary, is_muldiv;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign is_halt   = (opcode == 5'h1B);
    // Opcodes 0x00..0x12 have an execute phase; everything else except halt is a nop.
    assign is_exec   = (opcode <= 5'h12);
    assign is_binary = (opcode <= 5'h10);
    assign is_muldiv = (opcode == 5'h0F) || (opcode == 5'h10);

    // Low IR bits carry fields that none of these instruction classes use.
    assign unused_ir = ^ir[14:0];

    // State register; clr forces RST without waiting for a clock edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= RST;
        else
            state <= next_state;
    end

    // Retired-instruction counter, bumped on the edge that leaves a retiring step.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            instr_count <= 16'h0000;
        else if (retire)
            instr_count <= instr_count + 16'h0001;
    end

    // Next-state and control decode. Every control defaults low so each state
    // only lists the strobes it raises.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        PCout      = 1'b0;
        ZLowout    = 1'b0;
        ZHighout   = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        ZLowIn     = 1'b0;
        ZHighIn    = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Rout       = 16'h0000;
        Rin        = 16'h0000;
        operation  = 5'h00;
        run        = 1'b1;

        case (state)
            RST: next_state = T0;
            T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                next_state = T1;
            end
            T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready)
                    next_state = T2;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                // The branch uses the IR value being loaded on this edge.
                if (is_halt)
                    next_state = HALT;
                else if (is_exec)
                    next_state = T3;
                else begin
                    retire     = 1'b1;
                    next_state = T0;
                end
            end
            T3: begin
                Rout = 16'h0001 << rb;
                if (is_binary) begin
                    Yin        = 1'b1;
                    next_state = T4;
                end else begin
                    // Unary ops go straight through the ALU with Y unused.
                    operation  = opcode;
                    ZLowIn     = 1'b1;
                    next_state = T5;
                end
            end
            T4: begin
                Rout       = 16'h0001 << rc;
                operation  = opcode;
                ZLowIn     = 1'b1;
                ZHighIn    = 1'b1;
                next_state = T5;
            end
            T5: begin
                ZLowout = 1'b1;
                if (is_muldiv) begin
                    LOin       = 1'b1;
                    next_state = T6;
                end else begin
                    // R0 is hardwired, so its load enable is never raised.
                    Rin        = (ra != 4'd0) ? (16'h0001 << ra) : 16'h0000;
                    retire     = 1'b1;
                    next_state = T0;
                end
            end
            T6: begin
                ZHighout   = 1'b1;
                HIin       = 1'b1;
                retire     = 1'b1;
                next_state = T0;
            end
            HALT: run = 1'b0;
            default: next_state = RST;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//
// Self-checking bench for control_sequencer. An instruction-level reference
// model turns (ir, memory wait count) into the expected per-cycle list of
// control words; directed table vectors, hand sequences for clr/halt/wrap,
// and randomized instructions are all compared against it cycle by cycle.

module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        mem_ready;
    logic        PCout, ZLowout, ZHighout, MDRout;
    logic        MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
    logic        IncPC, Read;
    logic [15:0] Rout, Rin;
    logic [4:0]  operation;
    logic        run;
    logic [15:0] instr_count;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin),
        .operation(operation), .run(run), .instr_count(instr_count)
    );

    typedef struct packed {
        logic        PCout, ZLowout, ZHighout, MDRout;
        logic        MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
        logic        IncPC, Read;
        logic [15:0] Rout;
        logic [15:0] Rin;
        logic [4:0]  operation;
        logic        run;
    } ctl_t;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        int          cycles;
        logic [15:0] rin;
    } vec_t;

    ctl_t        exp_q[$];
    bit          aligned;
    logic [15:0] model_count;
    int          errors;
    int          checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic ctl_t snapshot();
        ctl_t s;
        s = '{PCout, ZLowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin,
              ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Rout, Rin, operation, run};
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model: lists the control word of every cycle of one
    // instruction from fetch to retirement (or into 100 cycles of halt).
    task automatic buildSchedule(input logic [31:0] instr, input int waits, output bit halts);
        ctl_t       c;
        ctl_t       base;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = instr[31:27];
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        base = '0;
        base.run = 1'b1;
        exp_q.delete();
        c = base; c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; exp_q.push_back(c);
        for (int w = 0; w <= waits; w++) begin
            c = base; c.Read = 1'b1; c.MDRin = 1'b1; exp_q.push_back(c);
        end
        c = base; c.MDRout = 1'b1; c.IRin = 1'b1; exp_q.push_back(c);
        halts = (op == 5'h1B);
        if (op <= 5'h10) begin
            c = base; c.Rout = 16'h0001 << rb; c.Yin = 1'b1; exp_q.push_back(c);
            c = base; c.Rout = 16'h0001 << rc; c.operation = op;
            c.ZLowIn = 1'b1; c.ZHighIn = 1'b1; exp_q.push_back(c);
            if (op >= 5'h0F) begin
                c = base; c.ZLowout = 1'b1; c.LOin = 1'b1; exp_q.push_back(c);
                c = base; c.ZHighout = 1'b1; c.HIin = 1'b1; exp_q.push_back(c);
            end else begin
                c = base; c.ZLowout = 1'b1;
                c.Rin = (ra == 4'd0) ? 16'h0000 : (16'h0001 << ra);
                exp_q.push_back(c);
            end
        end else if (op == 5'h11 || op == 5'h12) begin
            c = base; c.Rout = 16'h0001 << rb; c.operation = op; c.ZLowIn = 1'b1;
            exp_q.push_back(c);
            c = base; c.ZLowout = 1'b1;
            c.Rin = (ra == 4'd0) ? 16'h0000 : (16'h0001 << ra);
            exp_q.push_back(c);
        end
        if (halts)
            for (int h = 0; h < 100; h++) exp_q.push_back(ctl_t'(0));
    endtask

    // Runs one instruction: garbage IR until T2, mem_ready low for 'waits'
    // T1 cycles, compares every cycle and measures time until the next T0.
    task automatic applyStimulus(input logic [31:0] instr, input int waits,
                                 output int cycles, output logic [15:0] rin_seen);
        bit halts;
        bit done;
        int limit;
        buildSchedule(instr, waits, halts);
        rin_seen = 16'h0000;
        cycles   = 0;
        done     = 1'b0;
        limit    = exp_q.size() + (halts ? 0 : 20);
        for (int k = 0; k < limit; k++) begin
            if (k > 0 || !aligned) begin
                @(negedge clk);
                #1;
            end
            if (!halts && k > 0 && PCout) begin
                cycles = k;
                done   = 1'b1;
                break;
            end
            if (k < exp_q.size())
                checkOutput("step", 64'(snapshot()), 64'(exp_q[k]));
            else
                checkOutput("extra_cycle", 64'(k), 64'(exp_q.size()));
            rin_seen |= Rin;
            ir = (k <= waits + 1) ? $urandom() : instr;
            if (k >= 1 && k <= waits)
                mem_ready = 1'b0;
            else if (k == waits + 1)
                mem_ready = 1'b1;
            else
                mem_ready = 1'($urandom_range(0, 1));
        end
        if (halts) begin
            cycles  = limit;
            aligned = 1'b0;
        end else begin
            aligned = done;
            if (!done)
                checkOutput("next_T0_timeout", 64'(0), 64'(1));
            checkOutput("length", 64'(cycles), 64'(exp_q.size()));
            model_count = model_count + 16'h0001;
        end
        checkOutput("instr_count", 64'(instr_count), 64'(model_count));
    endtask

    task automatic applyReset();
        ctl_t rst_vec;
        rst_vec = '0;
        rst_vec.run = 1'b1;
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        checkOutput("reset_async", 64'(snapshot()), 64'(rst_vec));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_held", 64'(snapshot()), 64'(rst_vec));
        checkOutput("reset_count", 64'(instr_count), 64'(0));
        @(negedge clk);
        clr = 1'b0;
        aligned     = 1'b0;
        model_count = 16'h0000;
    endtask

    initial begin
        vec_t        tbl[11];
        int          cyc;
        logic [15:0] rin;
        ctl_t        rst_vec;
        logic [31:0] rnd;
        logic [4:0]  op;
        int          sel;

        tbl[0]  = '{32'h00918000, 0, 6, 16'h0002};   // add R1,R2,R3
        tbl[1]  = '{32'h00918000, 3, 9, 16'h0002};   // add with 3 wait cycles
        tbl[2]  = '{32'h78228000, 0, 7, 16'h0000};   // mul R4,R5
        tbl[3]  = '{32'h93380000, 0, 5, 16'h0040};   // not R6,R7
        tbl[4]  = '{32'h00118000, 0, 6, 16'h0000};   // add with Ra=0
        tbl[5]  = '{32'hD0000000, 0, 3, 16'h0000};   // nop 0x1A
        tbl[6]  = '{32'h80A18000, 1, 8, 16'h0000};   // div, one wait
        tbl[7]  = '{32'h8F880000, 0, 5, 16'h8000};   // neg R15,R1
        tbl[8]  = '{32'h72B38000, 2, 8, 16'h0020};   // opcode 0x0E into R5
        tbl[9]  = '{32'hF8000000, 1, 4, 16'h0000};   // nop 0x1F
        tbl[10] = '{32'h98000000, 0, 3, 16'h0000};   // nop 0x13

        errors      = 0;
        checks      = 0;
        clr         = 1'b1;
        ir          = 32'h0;
        mem_ready   = 1'b0;
        aligned     = 1'b0;
        model_count = 16'h0000;
        rst_vec     = '0;
        rst_vec.run = 1'b1;

        applyReset();

        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].ir, tbl[i].waits, cyc, rin);
            checkOutput("table_cycles", 64'(cyc), 64'(tbl[i].cycles));
            checkOutput("table_rin", 64'(rin), 64'(tbl[i].rin));
        end

        // clr in the middle of an add: everything drops at once.
        ir        = 32'h00918000;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("pre_clr_Yin", 64'(Yin), 64'(1));
        #2 clr = 1'b1;
        #1;
        checkOutput("clr_mid_outputs", 64'(snapshot()), 64'(rst_vec));
        checkOutput("clr_mid_count", 64'(instr_count), 64'(0));
        @(negedge clk);
        clr         = 1'b0;
        aligned     = 1'b0;
        model_count = 16'h0000;
        applyStimulus(32'hD0000000, 0, cyc, rin);

        // Halt holds for 100 cycles; only clr gets out.
        applyStimulus(32'hD8000000, 0, cyc, rin);
        checkOutput("halt_run", 64'(run), 64'(0));
        applyReset();
        applyStimulus(32'hD0000000, 0, cyc, rin);
        checkOutput("after_halt_count", 64'(instr_count), 64'(1));

        // Counter wrap: preload near the top, then retire two nops.
        force dut.instr_count = 16'hFFFE;
        #1 release dut.instr_count;
        model_count = 16'hFFFE;
        checkOutput("preload", 64'(instr_count), 64'(16'hFFFE));
        applyStimulus(32'hD0000000, 0, cyc, rin);
        applyStimulus(32'hD0000000, 1, cyc, rin);
        checkOutput("wrap_zero", 64'(instr_count), 64'(0));

        // Randomized instruction mix (no halt) against the model.
        for (int n = 0; n < 150; n++) begin
            rnd = $urandom();
            sel = $urandom_range(0, 9);
            if (sel <= 4)
                op = 5'($urandom_range(0, 14));
            else if (sel <= 6)
                op = 5'($urandom_range(15, 16));
            else if (sel == 7)
                op = 5'($urandom_range(17, 18));
            else begin
                op = 5'($urandom_range(19, 30));
                if (op == 5'h1B) op = 5'h1F;
            end
            rnd[31:27] = op;
            applyStimulus(rnd, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, cyc, rin);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
